priority_resolver_isr: RTL and testbench

- Consumer end of the IRR interface in the 8259A PIC.
- Takes the IRR's `risedBits` and resolves priority against the In-Service Register (ISR).
- Raises INT to the CPU and runs the two-pulse 8086 INTA acknowledge sequence.
- Returns `readPriority` and `resetIRR` to the IRR so the serviced request is cleared, and drives the interrupt vector onto the data buffer.

---
 rtl/priority_resolver_isr.sv | 225 ++++++++++++++++++++++
 tb/tb_priority_resolver_isr.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_resolver_isr.sv
// priority_resolver_isr: 8259A priority resolver, In-Service Register and 8086 INTA sequencer.
// Consumes the IRR's risedBits, raises the CPU interrupt and runs the two-pulse acknowledge.
// Optional feature: define AUTO_EOI_EN to add the autoEoi input (ICW4 AEOI).
// The CPU interrupt output is named intr because int is a reserved word.
module priority_resolver_isr #(
    parameter int unsigned NUM_IR = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] risedBits,
    input  logic              inta_n,
    input  logic              eoi,
    input  logic              specificEoi,
    input  logic [2:0]        eoiLevel,
    input  logic              rotateOnEoi,
    input  logic [4:0]        vectorBase,
`ifdef AUTO_EOI_EN
    input  logic              autoEoi,
`endif
    output logic              intr,
    output logic              readPriority,
    output logic [2:0]        resetIRR,
    output logic [NUM_IR-1:0] isr,
    output logic [7:0]        vectorOut,
    output logic              vectorOutEn
);

    localparam logic [NUM_IR-1:0] IrOne = {{(NUM_IR-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StAck1,
        StWait2
    } state_e;

    // Rotate right so that bit 0 of the result is the level sh of the input.
    function automatic logic [NUM_IR-1:0] rot_right(input logic [NUM_IR-1:0] v,
                                                     input logic [2:0] sh);
        logic [2*NUM_IR-1:0] t;
        t = {v, v} >> sh;
        return t[NUM_IR-1:0];
    endfunction

    // Index of the lowest set bit, or NUM_IR when nothing is set.
    function automatic logic [3:0] first_set(input logic [NUM_IR-1:0] v);
        logic [3:0] idx;
        idx = 4'(NUM_IR);
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    state_e            r_state, w_state_next;
    logic              r_inta_prev;
    logic              r_int, w_int_next;
    logic              r_rp, w_rp_next;
    logic [2:0]        r_level, w_level_next;
    logic [7:0]        r_vec, w_vec_next;
    logic              r_vec_en, w_vec_en_next;
    logic [NUM_IR-1:0] r_isr, w_isr_next;
    logic [2:0]        r_low_pri, w_low_pri_next;

    logic              w_inta_fall, w_inta_rise;
    logic [2:0]        w_base;
    logic [3:0]        w_req_first, w_isr_first;
    logic              w_req_valid, w_isr_any;
    logic [2:0]        w_req_level, w_isr_level;
    logic [NUM_IR-1:0] w_set_mask, w_clr_mask;
`ifdef AUTO_EOI_EN
    logic              r_spurious, w_spurious_next;
    logic              w_ack_done;
`endif

    // Edge detection on the acknowledge strobe against the previous sampled value.
    assign w_inta_fall = r_inta_prev & ~inta_n;
    assign w_inta_rise = ~r_inta_prev & inta_n;

    // Priority resolution: rotate so the highest-priority level sits at bit 0, then
    // the lowest set bit wins; a request is valid when it ranks above the ISR's top bit.
    always_comb begin
        w_base      = r_low_pri + 3'd1;
        w_req_first = first_set(rot_right(risedBits, w_base));
        w_isr_first = first_set(rot_right(r_isr, w_base));
        w_req_valid = (w_req_first < w_isr_first);
        w_isr_any   = |r_isr;
        w_req_level = w_base + w_req_first[2:0];
        w_isr_level = w_base + w_isr_first[2:0];
    end

    // FSM next state and sequencing outputs.
    always_comb begin
        w_state_next  = r_state;
        w_int_next    = 1'b0;
        w_rp_next     = 1'b0;
        w_level_next  = r_level;
        w_vec_next    = r_vec;
        w_vec_en_next = r_vec_en;
        w_set_mask    = '0;
`ifdef AUTO_EOI_EN
        w_spurious_next = r_spurious;
        w_ack_done      = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_req_valid) begin
                    w_state_next = StReq;
                    w_int_next   = 1'b1;
                end
            end
            StReq: begin
                if (w_inta_fall) begin
                    w_state_next = StAck1;
                    if (w_req_valid) begin
                        w_level_next = w_req_level;
                        w_set_mask   = IrOne << w_req_level;
                        w_rp_next    = 1'b1;
                    end else begin
                        // Request vanished under INTA: answer with the IR7 vector.
                        w_level_next = 3'd7;
                    end
`ifdef AUTO_EOI_EN
                    w_spurious_next = ~w_req_valid;
`endif
                end else if (!w_req_valid) begin
                    w_state_next = StIdle;
                end else begin
                    w_int_next = 1'b1;
                end
            end
            StAck1: begin
                if (w_inta_rise) w_state_next = StWait2;
            end
            StWait2: begin
                if (w_inta_fall && !r_vec_en) begin
                    w_vec_next    = {vectorBase, r_level};
                    w_vec_en_next = 1'b1;
                end else if (w_inta_rise && r_vec_en) begin
                    w_vec_en_next = 1'b0;
                    w_state_next  = StIdle;
`ifdef AUTO_EOI_EN
                    w_ack_done = 1'b1;
`endif
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // EOI handling on the pre-update ISR; an acknowledge set of the same bit wins.
    always_comb begin
        w_clr_mask     = '0;
        w_low_pri_next = r_low_pri;
        if (eoi) begin
            if (specificEoi) begin
                w_clr_mask = IrOne << eoiLevel;
                if (rotateOnEoi) w_low_pri_next = eoiLevel;
            end else if (w_isr_any) begin
                w_clr_mask = IrOne << w_isr_level;
                if (rotateOnEoi) w_low_pri_next = w_isr_level;
            end
        end
`ifdef AUTO_EOI_EN
        // A spurious acknowledge never set an ISR bit, so it must not clear one.
        if (w_ack_done && autoEoi && !r_spurious) begin
            w_clr_mask = w_clr_mask | (IrOne << r_level);
            if (rotateOnEoi && !eoi) w_low_pri_next = r_level;
        end
`endif
        w_isr_next = (r_isr & ~w_clr_mask) | w_set_mask;
    end

    // Sample INTA for edge detection; idles high so reset never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_inta_prev <= 1'b1;
        else        r_inta_prev <= inta_n;
    end

    // FSM state and acknowledge sequencing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_int    <= 1'b0;
            r_rp     <= 1'b0;
            r_level  <= 3'd0;
            r_vec    <= 8'd0;
            r_vec_en <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_int    <= w_int_next;
            r_rp     <= w_rp_next;
            r_level  <= w_level_next;
            r_vec    <= w_vec_next;
            r_vec_en <= w_vec_en_next;
        end
    end

`ifdef AUTO_EOI_EN
    // Remembers whether the current acknowledge was spurious.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_spurious <= 1'b0;
        else        r_spurious <= w_spurious_next;
    end
`endif

    // In-Service Register and rotating lowest-priority pointer (IR0 highest out of reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_isr     <= '0;
            r_low_pri <= 3'd7;
        end else begin
            r_isr     <= w_isr_next;
            r_low_pri <= w_low_pri_next;
        end
    end

    assign intr         = r_int;
    assign readPriority = r_rp;
    assign resetIRR     = r_level;
    assign isr          = r_isr;
    assign vectorOut    = r_vec;
    assign vectorOutEn  = r_vec_en;

endmodule

// File: tb/tb_priority_resolver_isr.sv
// tb_priority_resolver_isr: directed and randomized checks of priority_resolver_isr
// against a transaction-level model of priority ranking, ISR and EOI rules.
module tb_priority_resolver_isr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] risedBits;
    logic       inta_n;
    logic       eoi;
    logic       specificEoi;
    logic [2:0] eoiLevel;
    logic       rotateOnEoi;
    logic [4:0] vectorBase;
`ifdef AUTO_EOI_EN
    logic       autoEoi;
`endif
    logic       intr;
    logic       readPriority;
    logic [2:0] resetIRR;
    logic [7:0] isr;
    logic [7:0] vectorOut;
    logic       vectorOutEn;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [7:0] m_isr;
    int         m_lowpri;

    priority_resolver_isr #(.NUM_IR(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .risedBits   (risedBits),
        .inta_n      (inta_n),
        .eoi         (eoi),
        .specificEoi (specificEoi),
        .eoiLevel    (eoiLevel),
        .rotateOnEoi (rotateOnEoi),
        .vectorBase  (vectorBase),
`ifdef AUTO_EOI_EN
        .autoEoi     (autoEoi),
`endif
        .intr        (intr),
        .readPriority(readPriority),
        .resetIRR    (resetIRR),
        .isr         (isr),
        .vectorOut   (vectorOut),
        .vectorOutEn (vectorOutEn)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rank 0 is the highest priority: the level just after lowPri on the ring.
    function automatic int rank(input int lvl, input int lp);
        return (lvl - lp + 15) % 8;
    endfunction

    function automatic int top(input logic [7:0] v, input int lp);
        int best;
        best = -1;
        for (int i = 0; i < 8; i++) begin
            if (v[i] && (best < 0 || rank(i, lp) < rank(best, lp))) best = i;
        end
        return best;
    endfunction

    function automatic logic qualifies(input logic [7:0] r, input logic [7:0] s, input int lp);
        int tr;
        int ts;
        tr = top(r, lp);
        ts = top(s, lp);
        if (tr < 0) return 1'b0;
        return (ts < 0) || (rank(tr, lp) < rank(ts, lp));
    endfunction

    // Full two-pulse acknowledge; lvl < 0 means a spurious acknowledge is expected.
    task automatic do_ack(input int lvl);
        int vl;
        vl = (lvl >= 0) ? lvl : 7;
        if (lvl >= 0) m_isr[lvl] = 1'b1;
        inta_n = 1'b0;
        step();
        chk("ack_readPriority", readPriority, (lvl >= 0) ? 1 : 0);
        if (lvl >= 0) begin
            chk("ack_resetIRR", resetIRR, lvl);
            risedBits[lvl] = 1'b0;
        end
        chk("ack_isr", isr, m_isr);
        chk("ack_int_drop", intr, 0);
        step();
        chk("readPriority_one_cycle", readPriority, 0);
        inta_n = 1'b1;
        step();
        step();
        chk("no_drive_first_pulse", vectorOutEn, 0);
        inta_n = 1'b0;
        step();
        chk("vectorOutEn_on", vectorOutEn, 1);
        chk("vectorOut", vectorOut, {vectorBase, 3'(vl)});
        inta_n = 1'b1;
`ifdef AUTO_EOI_EN
        if (autoEoi && lvl >= 0) begin
            m_isr[lvl] = 1'b0;
            if (rotateOnEoi) m_lowpri = lvl;
        end
`endif
        step();
        chk("vectorOutEn_off", vectorOutEn, 0);
        chk("isr_after_ack", isr, m_isr);
    endtask

    task automatic eoi_op(input logic spec, input logic [2:0] lvl, input logic rot);
        int t;
        eoi         = 1'b1;
        specificEoi = spec;
        eoiLevel    = lvl;
        rotateOnEoi = rot;
        if (spec) begin
            m_isr[lvl] = 1'b0;
            if (rot) m_lowpri = int'(lvl);
        end else begin
            t = top(m_isr, m_lowpri);
            if (t >= 0) begin
                m_isr[t] = 1'b0;
                if (rot) m_lowpri = t;
            end
        end
        step();
        eoi         = 1'b0;
        specificEoi = 1'b0;
        rotateOnEoi = 1'b0;
        chk("eoi_isr", isr, m_isr);
    endtask

    initial begin
        logic [7:0] r;
        logic       v;

        rst_n       = 1'b0;
        risedBits   = 8'd0;
        inta_n      = 1'b1;
        eoi         = 1'b0;
        specificEoi = 1'b0;
        eoiLevel    = 3'd0;
        rotateOnEoi = 1'b0;
        vectorBase  = 5'd0;
`ifdef AUTO_EOI_EN
        autoEoi     = 1'b0;
`endif
        m_isr    = 8'd0;
        m_lowpri = 7;
        step();
        step();
        chk("rst_int", intr, 0);
        chk("rst_readPriority", readPriority, 0);
        chk("rst_resetIRR", resetIRR, 0);
        chk("rst_isr", isr, 0);
        chk("rst_vectorOut", vectorOut, 0);
        chk("rst_vectorOutEn", vectorOutEn, 0);

        // Basic acknowledge: IR2 wins over IR5, vector 0x0A.
        rst_n      = 1'b1;
        vectorBase = 5'b00001;
        risedBits  = 8'b0010_0100;
        #0 chk("int_latency", intr, 0);
        step();
        chk("basic_int", intr, 1);
        do_ack(2);
        chk("basic_isr", isr, 8'b0000_0100);

        // Nesting: IR5 is masked by IR2 in service, IR0 nests.
        risedBits = 8'b0010_0000;
        step();
        chk("nest_blocked", intr, 0);
        step();
        chk("nest_blocked_hold", intr, 0);
        risedBits = 8'b0000_0001;
        step();
        chk("nest_int", intr, 1);
        do_ack(0);
        chk("nest_isr", isr, 8'b0000_0101);

        // Non-specific EOI with rotation: IR0 cleared and becomes lowest.
        eoi_op(1'b0, 3'd0, 1'b1);
        chk("rot_isr", isr, 8'b0000_0100);
        risedBits = 8'b0000_0011;
        step();
        chk("rot_int", intr, 1);
        do_ack(1);

        // Drain and restore IR0 as highest via a specific rotating EOI on IR7.
        eoi_op(1'b1, 3'd1, 1'b0);
        eoi_op(1'b1, 3'd2, 1'b0);
        eoi_op(1'b1, 3'd7, 1'b1);
        risedBits = 8'b0000_0000;
        step();

        // Spurious: request withdrawn in the same cycle INTA falls.
        vectorBase = 5'b10101;
        risedBits  = 8'b0000_1000;
        step();
        chk("spur_int", intr, 1);
        risedBits = 8'b0000_0000;
        do_ack(-1);
        chk("spur_isr", isr, 8'd0);

        // Reset between INTA1 and INTA2.
        risedBits = 8'b0001_0000;
        step();
        chk("mid_int", intr, 1);
        inta_n = 1'b0;
        step();
        chk("mid_ack_isr", isr, 8'b0001_0000);
        risedBits = 8'd0;
        step();
        inta_n = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_isr", isr, 0);
        chk("mid_rst_int", intr, 0);
        chk("mid_rst_en", vectorOutEn, 0);
        m_isr    = 8'd0;
        m_lowpri = 7;
        step();
        rst_n  = 1'b1;
        inta_n = 1'b0;
        step();
        step();
        chk("post_rst_inta_en", vectorOutEn, 0);
        chk("post_rst_inta_rp", readPriority, 0);
        inta_n = 1'b1;
        step();
        chk("post_rst_inta_en2", vectorOutEn, 0);
        risedBits = 8'b0000_0010;
        step();
        chk("post_rst_int", intr, 1);
        do_ack(1);
        eoi_op(1'b0, 3'd0, 1'b0);

`ifdef AUTO_EOI_EN
        // Automatic EOI with rotation: IR5 cleared on the second INTA rising edge.
        autoEoi     = 1'b1;
        rotateOnEoi = 1'b1;
        risedBits   = 8'b0010_0000;
        step();
        chk("aeoi_int", intr, 1);
        do_ack(5);
        chk("aeoi_isr", isr, 8'd0);
        autoEoi     = 1'b0;
        rotateOnEoi = 1'b0;
`endif

        // Randomized requests and EOIs against the model.
        for (int it = 0; it < 80; it++) begin
            vectorBase = 5'($urandom);
            r          = 8'($urandom_range(1, 255));
            risedBits  = r;
            v          = qualifies(r, m_isr, m_lowpri);
            step();
            chk("rnd_int", intr, v);
            if (v) do_ack(top(r, m_lowpri));
            if ($urandom_range(0, 2) != 0) begin
                eoi_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
